lz_symbol_resolver: RTL and testbench

//  Downstream of huffman_decoder in LZ-sequence mode. Consumes decoded

---
 rtl/lz_symbol_resolver_pkg.sv | 61 ++++++
 rtl/lz_symbol_resolver_if.sv | 27 ++
 rtl/lz_symbol_resolver_base_lut.sv | 30 +++
 rtl/lz_symbol_resolver.sv | 120 ++++++++++++
 tb/tb_lz_symbol_resolver.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lz_symbol_resolver_pkg.sv
// rtl/lz_symbol_resolver_pkg.sv - DEFLATE length/distance tables, command and state types
package lz_symbol_resolver_pkg;

  localparam int SYM_W = 9;
  localparam int EXT_W = 13;

  typedef enum logic [1:0] {
    CMD_LIT  = 2'd0,
    CMD_COPY = 2'd1,
    CMD_EOB  = 2'd2
  } cmd_type_e;

  typedef enum logic [1:0] {
    S_LIT  = 2'd0,
    S_DIST = 2'd1,
    S_ERR  = 2'd2
  } state_e;

  // Length symbols 257..285
  localparam logic [8:0] LEN_BASE [29] = '{
    9'd3,   9'd4,   9'd5,   9'd6,   9'd7,   9'd8,   9'd9,   9'd10,
    9'd11,  9'd13,  9'd15,  9'd17,  9'd19,  9'd23,  9'd27,  9'd31,
    9'd35,  9'd43,  9'd51,  9'd59,  9'd67,  9'd83,  9'd99,  9'd115,
    9'd131, 9'd163, 9'd195, 9'd227, 9'd258
  };
  localparam logic [3:0] LEN_EXT [29] = '{
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
    4'd1, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2,
    4'd3, 4'd3, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd4,
    4'd5, 4'd5, 4'd5, 4'd5, 4'd0
  };

  // Distance symbols 0..29
  localparam logic [15:0] DIST_BASE [30] = '{
    16'd1,     16'd2,     16'd3,     16'd4,     16'd5,     16'd7,
    16'd9,     16'd13,    16'd17,    16'd25,    16'd33,    16'd49,
    16'd65,    16'd97,    16'd129,   16'd193,   16'd257,   16'd385,
    16'd513,   16'd769,   16'd1025,  16'd1537,  16'd2049,  16'd3073,
    16'd4097,  16'd6145,  16'd8193,  16'd12289, 16'd16385, 16'd24577
  };
  localparam logic [3:0] DIST_EXT [30] = '{
    4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd2,  4'd2,
    4'd3,  4'd3,  4'd4,  4'd4,  4'd5,  4'd5,  4'd6,  4'd6,
    4'd7,  4'd7,  4'd8,  4'd8,  4'd9,  4'd9,  4'd10, 4'd10,
    4'd11, 4'd11, 4'd12, 4'd12, 4'd13, 4'd13
  };

  // Number of extra bits following a symbol; 0 for symbols that carry none
  function automatic logic [3:0] ext_len(input logic [8:0] sym, input logic is_dist);
    logic [4:0] idx;
    idx = 5'(sym - 9'd257);
    if (is_dist) begin
      return (sym < 9'd30) ? DIST_EXT[sym[4:0]] : 4'd0;
    end
    if (sym >= 9'd257 && sym <= 9'd285) begin
      return LEN_EXT[idx];
    end
    return 4'd0;
  endfunction

endpackage

// File: rtl/lz_symbol_resolver_if.sv
// rtl/lz_symbol_resolver_if.sv - symbol input and command output handshake bundle
interface lz_symbol_resolver_if;
  import lz_symbol_resolver_pkg::*;

  logic             sym_vld;
  logic [SYM_W-1:0] sym;
  logic [EXT_W-1:0] sym_ext;
  logic             sym_rdy;
  logic             dist_mode;
  logic             out_vld;
  logic [1:0]       out_type;
  logic [7:0]       out_lit;
  logic [8:0]       out_len;
  logic [15:0]      out_dist;
  logic             out_rdy;
  logic             err;

  modport master (
    output sym_vld, sym, sym_ext, out_rdy,
    input  sym_rdy, dist_mode, out_vld, out_type, out_lit, out_len, out_dist, err
  );

  modport slave (
    input  sym_vld, sym, sym_ext, out_rdy,
    output sym_rdy, dist_mode, out_vld, out_type, out_lit, out_len, out_dist, err
  );
endinterface

// File: rtl/lz_symbol_resolver_base_lut.sv
// rtl/lz_symbol_resolver_base_lut.sv - symbol to {base, extra-bit count, illegal} lookup
module lz_base_lut
  import lz_symbol_resolver_pkg::*;
(
  input  logic [8:0]  sym,
  input  logic        is_dist,
  output logic [15:0] base,
  output logic [3:0]  ext_cnt,
  output logic        illegal
);

  logic [4:0] len_idx;
  assign len_idx = 5'(sym - 9'd257);

  // Literals and EOB have no base; out-of-alphabet symbols flag illegal
  always_comb begin
    base    = '0;
    ext_cnt = ext_len(sym, is_dist);
    illegal = 1'b0;
    if (is_dist) begin
      if (sym < 9'd30) base = DIST_BASE[sym[4:0]];
      else             illegal = 1'b1;
    end else if (sym >= 9'd286) begin
      illegal = 1'b1;
    end else if (sym >= 9'd257) begin
      base = 16'(LEN_BASE[len_idx]);
    end
  end

endmodule

// File: rtl/lz_symbol_resolver.sv
// rtl/lz_symbol_resolver.sv - LZ lit/len + distance symbol to command resolver; LZ_RESOLVER_STAT_EN adds delivery counters
module lz_symbol_resolver
  import lz_symbol_resolver_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  lz_symbol_resolver_if.slave bus
`ifdef LZ_RESOLVER_STAT_EN
  ,
  output logic [31:0]         stat_lit,
  output logic [31:0]         stat_copy
`endif
);

  state_e           state, state_nxt;
  logic [8:0]       len_q;
  logic             accept, drain, emit;
  logic [15:0]      lut_base;
  logic [3:0]       lut_ext;
  logic             lut_illegal;
  logic [EXT_W-1:0] ext_mask;
  logic [15:0]      value;

  lz_base_lut u_lut (
    .sym     (bus.sym),
    .is_dist (state == S_DIST),
    .base    (lut_base),
    .ext_cnt (lut_ext),
    .illegal (lut_illegal)
  );

  // Extra bits beyond the symbol's count are ignored
  assign ext_mask = ~({EXT_W{1'b1}} << lut_ext);
  assign value    = lut_base + {3'b000, bus.sym_ext & ext_mask};

  assign accept = bus.sym_vld & bus.sym_rdy;
  assign drain  = bus.out_vld & bus.out_rdy;
  assign emit   = ((state == S_LIT) && (bus.sym <= 9'd256)) ||
                  ((state == S_DIST) && !lut_illegal);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_LIT;
    else        state <= state_nxt;
  end

  // Next state: moves only on an accepted symbol; S_ERR is left only by reset
  always_comb begin
    state_nxt = state;
    if (accept) begin
      case (state)
        S_LIT:   if (lut_illegal)              state_nxt = S_ERR;
                 else if (bus.sym > 9'd256)    state_nxt = S_DIST;
        S_DIST:  state_nxt = lut_illegal ? S_ERR : S_LIT;
        default: state_nxt = state;
      endcase
    end
  end

  // Handshake outputs derived from the registered state and output slot
  always_comb begin
    bus.sym_rdy   = (state != S_ERR) & (~bus.out_vld | bus.out_rdy);
    bus.dist_mode = (state == S_DIST);
  end

  // Length held between the length symbol and its distance symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                              len_q <= '0;
    else if (accept && state == S_LIT && bus.sym > 9'd256 && !lut_illegal)
                                                             len_q <= value[8:0];
  end

  // Single output slot: load on an emitting accept, clear when drained
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_vld  <= 1'b0;
      bus.out_type <= CMD_LIT;
      bus.out_lit  <= '0;
      bus.out_len  <= '0;
      bus.out_dist <= '0;
    end else if (accept && emit) begin
      bus.out_vld <= 1'b1;
      bus.out_lit <= '0;
      bus.out_len <= '0;
      bus.out_dist <= '0;
      if (state == S_DIST) begin
        bus.out_type <= CMD_COPY;
        bus.out_len  <= len_q;
        bus.out_dist <= value;
      end else if (bus.sym == 9'd256) begin
        bus.out_type <= CMD_EOB;
      end else begin
        bus.out_type <= CMD_LIT;
        bus.out_lit  <= bus.sym[7:0];
      end
    end else if (drain) begin
      bus.out_vld <= 1'b0;
    end
  end

  // Sticky error on any accepted out-of-alphabet symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    bus.err <= 1'b0;
    else if (accept && lut_illegal) bus.err <= 1'b1;
  end

`ifdef LZ_RESOLVER_STAT_EN
  // Saturating counts of delivered literal and copy commands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lit  <= '0;
      stat_copy <= '0;
    end else if (drain) begin
      if (bus.out_type == CMD_LIT && stat_lit != '1)   stat_lit  <= stat_lit + 32'd1;
      if (bus.out_type == CMD_COPY && stat_copy != '1) stat_copy <= stat_copy + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lz_symbol_resolver.sv
// tb/tb_lz_symbol_resolver.sv - randomized self-checking bench for lz_symbol_resolver
module tb_lz_symbol_resolver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lz_symbol_resolver_if bus();

`ifdef LZ_RESOLVER_STAT_EN
  logic [31:0] stat_lit, stat_copy;
`endif

  lz_symbol_resolver dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef LZ_RESOLVER_STAT_EN
    ,
    .stat_lit  (stat_lit),
    .stat_copy (stat_copy)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // DEFLATE tables generated from their construction rule
  int lbase[29], lext[29], dbase[30], dext[30];

  function automatic void build_tables();
    lbase[0] = 3;
    for (int i = 0; i < 29; i++) begin
      lext[i] = (i < 8) ? 0 : (i - 4) / 4;
      if (i > 0) lbase[i] = lbase[i-1] + (1 << lext[i-1]);
    end
    lbase[28] = 258;
    lext[28]  = 0;
    dbase[0] = 1;
    for (int i = 0; i < 30; i++) begin
      dext[i] = (i < 4) ? 0 : (i - 2) / 2;
      if (i > 0) dbase[i] = dbase[i-1] + (1 << dext[i-1]);
    end
  endfunction

  function automatic int len_of(input int s, input int e);
    return lbase[s-257] + (e % (1 << lext[s-257]));
  endfunction

  function automatic int dist_of(input int s, input int e);
    return dbase[s] + (e % (1 << dext[s]));
  endfunction

  // Reference model: mode 0 lit/len, 1 distance, 2 error
  int     m_mode = 0, m_len = 0;
  bit     m_vld = 0, m_err = 0;
  int     m_type = 0, m_lit = 0, m_olen = 0, m_dist = 0;
  longint m_slit = 0, m_scopy = 0;
  bit     m_rdy;
  int     ms, me;
  int     dut_lits[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_len = 0; m_vld = 0; m_err = 0;
      m_type = 0; m_lit = 0; m_olen = 0; m_dist = 0;
      m_slit = 0; m_scopy = 0;
    end else begin
      m_rdy = (m_mode != 2) && (!m_vld || bus.out_rdy);
      if (m_vld && bus.out_rdy) begin
        m_vld = 0;
        if (m_type == 0 && m_slit != 64'hFFFF_FFFF) m_slit++;
        if (m_type == 1 && m_scopy != 64'hFFFF_FFFF) m_scopy++;
      end
      if (bus.sym_vld && m_rdy) begin
        ms = int'(bus.sym);
        me = int'(bus.sym_ext);
        if (m_mode == 0) begin
          if (ms < 256) begin
            m_vld = 1; m_type = 0; m_lit = ms;
          end else if (ms == 256) begin
            m_vld = 1; m_type = 2;
          end else if (ms <= 285) begin
            m_len = len_of(ms, me); m_mode = 1;
          end else begin
            m_err = 1; m_mode = 2;
          end
        end else begin
          if (ms < 30) begin
            m_vld = 1; m_type = 1; m_olen = m_len; m_dist = dist_of(ms, me); m_mode = 0;
          end else begin
            m_err = 1; m_mode = 2;
          end
        end
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    check("sym_rdy", bus.sym_rdy, (m_mode != 2) && (!m_vld || bus.out_rdy));
    check("dist_mode", bus.dist_mode, m_mode == 1);
    check("err", bus.err, m_err);
    check("out_vld", bus.out_vld, m_vld);
    if (m_vld) begin
      check("out_type", bus.out_type, m_type);
      if (m_type == 0) check("out_lit", bus.out_lit, m_lit);
      if (m_type == 1) begin
        check("out_len", bus.out_len, m_olen);
        check("out_dist", bus.out_dist, m_dist);
      end
    end
`ifdef LZ_RESOLVER_STAT_EN
    check("stat_lit", stat_lit, m_slit);
    check("stat_copy", stat_copy, m_scopy);
`endif
    if (bus.out_vld && bus.out_rdy && bus.out_type == 2'd0) dut_lits.push_back(int'(bus.out_lit));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input int s, input int e);
    bit acc;
    acc = 0;
    bus.sym_vld = 1'b1;
    bus.sym     = 9'(s);
    bus.sym_ext = 13'(e);
    for (int i = 0; i < 64 && !acc; i++) begin
      @(negedge clk);
      acc = bus.sym_rdy;
      step();
    end
    bus.sym_vld = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: symbol %0d not accepted within 64 cycles", s);
    end
  endtask

  int n0, r;

  initial begin
    build_tables();
    check("model_len_265", len_of(265, 1), 12);
    check("model_len_285", len_of(285, 'h1F), 258);
    check("model_dist_4", dist_of(4, 1), 6);
    check("model_dist_29", dist_of(29, 'h1FFF), 32768);

    bus.sym_vld = 1'b0; bus.sym = '0; bus.sym_ext = '0; bus.out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    @(negedge clk);
    check("rst_out_vld", bus.out_vld, 0);
    check("rst_dist_mode", bus.dist_mode, 0);
    check("rst_err", bus.err, 0);
    step();

    send(65, 0);
    @(negedge clk);
    check("lit_vld", bus.out_vld, 1);
    check("lit_type", bus.out_type, 0);
    check("lit_val", bus.out_lit, 'h41);
    check("lit_mode", bus.dist_mode, 0);
    step();

    send(265, 1);
    @(negedge clk);
    check("len_mode", bus.dist_mode, 1);
    check("len_no_out", bus.out_vld, 0);
    step();
    send(4, 1);
    @(negedge clk);
    check("copy_type", bus.out_type, 1);
    check("copy_len", bus.out_len, 12);
    check("copy_dist", bus.out_dist, 6);
    check("copy_mode", bus.dist_mode, 0);
    step();

    send(285, 'h1F);
    send(29, 'h1FFF);
    @(negedge clk);
    check("max_len", bus.out_len, 258);
    check("max_dist", bus.out_dist, 32768);
    step();
    step();

    n0 = dut_lits.size();
    bus.out_rdy = 1'b0;
    send(16, 0);
    bus.sym_vld = 1'b1; bus.sym = 9'd17; bus.sym_ext = '0;
    repeat (3) begin
      @(negedge clk);
      check("stall_rdy", bus.sym_rdy, 0);
      check("stall_lit", bus.out_lit, 16);
      check("stall_vld", bus.out_vld, 1);
      step();
    end
    bus.out_rdy = 1'b1;
    send(17, 0);
    send(18, 0);
    step();
    step();
    check("order_count", dut_lits.size() - n0, 3);
    if (dut_lits.size() - n0 == 3) begin
      check("order_0", dut_lits[n0], 16);
      check("order_1", dut_lits[n0+1], 17);
      check("order_2", dut_lits[n0+2], 18);
    end

    send(256, 0);
    @(negedge clk);
    check("eob_type", bus.out_type, 2);
    check("eob_vld", bus.out_vld, 1);
    step();
    send(286, 0);
    repeat (3) begin
      @(negedge clk);
      check("err_flag", bus.err, 1);
      check("err_rdy", bus.sym_rdy, 0);
      step();
    end
    rst_n = 1'b0;
    @(negedge clk);
    check("err_cleared", bus.err, 0);
    step();
    rst_n = 1'b1;
    step();

    send(260, 0);
    @(negedge clk);
    check("mid_mode", bus.dist_mode, 1);
    step();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_mode", bus.dist_mode, 0);
    check("mid_rst_vld", bus.out_vld, 0);
`ifdef LZ_RESOLVER_STAT_EN
    check("mid_rst_slit", stat_lit, 0);
    check("mid_rst_scopy", stat_copy, 0);
`endif
    step();
    rst_n = 1'b1;
    step();
    send(66, 0);
    @(negedge clk);
    check("post_rst_type", bus.out_type, 0);
    check("post_rst_lit", bus.out_lit, 'h42);
    step();

    for (int c = 0; c < 4000; c++) begin
      if (m_mode == 2 || $urandom_range(0, 399) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      bus.out_rdy = ($urandom_range(0, 3) != 0);
      bus.sym_vld = ($urandom_range(0, 2) != 0);
      bus.sym_ext = 13'($urandom);
      if (m_mode == 1) begin
        bus.sym = ($urandom_range(0, 199) == 0) ? 9'(30 + $urandom_range(0, 1)) : 9'($urandom_range(0, 29));
      end else begin
        r = $urandom_range(0, 99);
        if (r < 40)      bus.sym = 9'($urandom_range(0, 255));
        else if (r < 45) bus.sym = 9'd256;
        else if (r < 99) bus.sym = 9'($urandom_range(257, 285));
        else             bus.sym = 9'($urandom_range(286, 287));
      end
      step();
    end

    bus.sym_vld = 1'b0;
    bus.out_rdy = 1'b1;
    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
